// File: rtl/kmul_pkg.sv
// Shared widths and defaults for the Karatsuba multiplier stream adapter.
package kmul_pkg;

   localparam int TAG_WIDTH_DEF = 4;

   function automatic int prod_w(input int width);
      return 2 * width;
   endfunction

   // Credit counters must hold the value DEPTH itself, hence the extra bit.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/kmul_sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered occupancy count.
module kmul_sync_fifo
   import kmul_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      push_i,
   input  logic [DATA_W-1:0]         wdata_i,
   input  logic                      pop_i,
   output logic [DATA_W-1:0]         rdata_o,
   output logic                      valid_o,
   output logic [cnt_w(DEPTH)-1:0]   count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CW    = cnt_w(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]     count_q, count_d;
   logic              pop_ok, push_ok;

   assign pop_ok  = pop_i && (count_q != '0);
   // A push into a full FIFO is only accepted when the head leaves in the same cycle.
   assign push_ok = push_i && ((count_q != CW'(DEPTH)) || pop_ok);

   always_comb begin
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      if (push_ok) wr_d = wr_q + PTR_W'(1);
      if (pop_ok)  rd_d = rd_q + PTR_W'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_q];
   assign valid_o = (count_q != '0);
   assign count_o = count_q;

endmodule

// File: rtl/kmul_stream_adapter.sv
// Valid/ready wrapper around a fixed-latency multiplier with credit-protected output FIFO.
// Optional sideband tags travel with each op when KMUL_ADAPTER_TAG_EN is defined.
module kmul_stream_adapter
   import kmul_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int FIFO_DEPTH = 8,
   parameter int TAG_WIDTH  = TAG_WIDTH_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         in_a,
   input  logic [WIDTH-1:0]         in_b,
`ifdef KMUL_ADAPTER_TAG_EN
   input  logic [TAG_WIDTH-1:0]     in_tag,
`endif
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [WIDTH-1:0]         mul_a,
   output logic [WIDTH-1:0]         mul_b,
   output logic                     mul_valid,
   input  logic [prod_w(WIDTH)-1:0] mul_product,
   input  logic                     mul_pvalid,
   output logic [prod_w(WIDTH)-1:0] out_product,
`ifdef KMUL_ADAPTER_TAG_EN
   output logic [TAG_WIDTH-1:0]     out_tag,
`endif
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     err_unexpected
);

   localparam int PW = prod_w(WIDTH);
   localparam int CW = cnt_w(FIFO_DEPTH);
`ifdef KMUL_ADAPTER_TAG_EN
   localparam int TAG_EN = 1;
`else
   localparam int TAG_EN = 0;
`endif
   localparam int OUT_W = PW + TAG_EN * TAG_WIDTH;

   logic [CW-1:0]    in_flight_q, in_flight_d, fifo_count;
   logic [CW:0]      credits_used;
   logic [WIDTH-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
   logic             mul_valid_q, err_q, err_d;
   logic             issue, capture, spurious, pop;
   logic [OUT_W-1:0] fifo_wdata, fifo_rdata;

   // Every slot is either in the multiplier pipe or in the FIFO; both terms are registered.
   assign credits_used = {1'b0, in_flight_q} + {1'b0, fifo_count};
   assign in_ready     = credits_used < (CW+1)'(FIFO_DEPTH);

   assign issue    = in_valid && in_ready;
   assign capture  = mul_pvalid && (in_flight_q != '0);
   assign spurious = mul_pvalid && (in_flight_q == '0);
   assign pop      = out_valid && out_ready;

   always_comb begin
      in_flight_d = in_flight_q;
      mul_a_d     = mul_a_q;
      mul_b_d     = mul_b_q;
      err_d       = err_q || spurious;
      if (issue && !capture)      in_flight_d = in_flight_q + CW'(1);
      else if (capture && !issue) in_flight_d = in_flight_q - CW'(1);
      if (issue) begin
         mul_a_d = in_a;
         mul_b_d = in_b;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         in_flight_q <= '0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         mul_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         in_flight_q <= in_flight_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
         mul_valid_q <= issue;
         err_q       <= err_d;
      end
   end

   assign mul_a          = mul_a_q;
   assign mul_b          = mul_b_q;
   assign mul_valid      = mul_valid_q;
   assign err_unexpected = err_q;

`ifdef KMUL_ADAPTER_TAG_EN
   logic [TAG_WIDTH-1:0] tag_head;
   logic                 tag_vld;

   // Tags queue in issue order; the in-order multiplier lets the head pair with each product.
   kmul_sync_fifo #(.DATA_W(TAG_WIDTH), .DEPTH(FIFO_DEPTH)) u_tag_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (issue),
      .wdata_i (in_tag),
      .pop_i   (capture),
      .rdata_o (tag_head),
      .valid_o (tag_vld),
      .count_o ()
   );

   assign fifo_wdata = {(tag_vld ? tag_head : '0), mul_product};
   assign out_tag    = fifo_rdata[PW +: TAG_WIDTH];
`else
   assign fifo_wdata = mul_product;
`endif

   kmul_sync_fifo #(.DATA_W(OUT_W), .DEPTH(FIFO_DEPTH)) u_out_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (capture),
      .wdata_i (fifo_wdata),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .valid_o (out_valid),
      .count_o (fifo_count)
   );

   assign out_product = fifo_rdata[PW-1:0];

endmodule
